// File: rtl/mc_core_pkg.sv
// Shared types for the multi-cycle accumulator core: opcodes, FSM states and
// the immediate sign-extension helper.
package mc_core_pkg;

  localparam int OP_W   = 4;
  localparam int SEXT_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_LDA  = 4'h0, OP_STA  = 4'h1, OP_JMP  = 4'h2, OP_JZ   = 4'h3,
    OP_ADD  = 4'h4, OP_SUB  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
    OP_NOT  = 4'h8, OP_MVTO = 4'h9, OP_MVFR = 4'hA, OP_ADDR = 4'hB,
    OP_ADDI = 4'hC, OP_NOP  = 4'hD, OP_HALT = 4'hE, OP_ILL  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_MEM_RD, ST_MEM_WR, ST_HALT
  } state_e;

  // Sign-extend the low w bits of v to SEXT_W bits; callers truncate.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
    logic [SEXT_W-1:0] hi;
    hi = {SEXT_W{1'b1}} << w;
    return (|(v & (hi >> 1) & ~hi)) ? (v | hi) : (v & ~hi);
  endfunction

endpackage

// File: rtl/mc_reg_file.sv
// REG_CNT x DATA_W register file: one sync write port, one comb read port,
// R0 (the accumulator) always visible on acc.
module mc_reg_file #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(REG_CNT)-1:0] waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(REG_CNT)-1:0] raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic [DATA_W-1:0]          acc
);

  logic [REG_CNT-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst)     regs        <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata = regs[raddr];
  assign acc   = regs[0];

endmodule

// File: rtl/mc_acc_core.sv
// Multi-cycle accumulator core: FETCH/DECODE/MEM_RD/MEM_WR/HALT control over a
// req/ack memory port with arbitrary wait states; R0 is the accumulator.
module mc_acc_core
  import mc_core_pkg::*;
#(
  parameter int                      DATA_W   = 16,
  parameter int                      REG_CNT  = 8,
  parameter logic [DATA_W-OP_W-1:0]  RESET_PC = '0,
  parameter int                      CNT_W    = 32,
  localparam int                     ADDR_W   = DATA_W - OP_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  localparam int IDX_W = $clog2(REG_CNT);

  state_e              state;
  opcode_e             op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm, ri, rf_wdata;
  logic [IDX_W-1:0]    rf_waddr;
  logic                rf_we, xfer;

  assign op      = opcode_e'(ir[DATA_W-1 -: OP_W]);
  assign operand = ir[ADDR_W-1:0];
  assign imm     = DATA_W'(sext(SEXT_W'(operand), ADDR_W));
  assign xfer    = mem_req && mem_ack;

  mc_reg_file #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (operand[IDX_W-1:0]),
    .rdata (ri),
    .acc   (acc)
  );

  // Register ops write in DECODE; memory reads write R0 on the ack edge.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = acc;
    if (state == ST_DECODE) begin
      case (op)
        OP_NOT:  begin rf_we = 1'b1; rf_wdata = ~acc;       end
        OP_MVTO: begin rf_we = 1'b1; rf_waddr = operand[IDX_W-1:0]; end
        OP_MVFR: begin rf_we = 1'b1; rf_wdata = ri;         end
        OP_ADDR: begin rf_we = 1'b1; rf_wdata = acc + ri;   end
        OP_ADDI: begin rf_we = 1'b1; rf_wdata = acc + imm;  end
        default: ;
      endcase
    end else if (state == ST_MEM_RD && xfer) begin
      rf_we = 1'b1;
      case (op)
        OP_ADD:  rf_wdata = acc + mem_rdata;
        OP_SUB:  rf_wdata = acc - mem_rdata;
        OP_AND:  rf_wdata = acc & mem_rdata;
        OP_OR:   rf_wdata = acc | mem_rdata;
        default: rf_wdata = mem_rdata;
      endcase
    end
  end

  // A state entered with mem_req low spends one idle cycle raising it; only
  // DECODE->FETCH raises it directly, since DECODE is itself an idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      retired   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            ir      <= mem_rdata;
            pc      <= pc + 1'b1;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state <= ST_MEM_RD;
            OP_STA:  state <= ST_MEM_WR;
            OP_HALT: begin state <= ST_HALT; halted <= 1'b1; end
            OP_ILL:  begin state <= ST_HALT; halted <= 1'b1; illegal <= 1'b1; end
            default: begin
              state   <= ST_FETCH;
              retired <= retired + 1'b1;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              if (op == OP_JMP || (op == OP_JZ && acc == '0)) begin
                pc       <= operand;
                mem_addr <= operand;
              end else begin
                mem_addr <= pc;
              end
            end
          endcase
        end
        ST_MEM_RD, ST_MEM_WR: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= (state == ST_MEM_WR);
            mem_addr  <= operand;
            mem_wdata <= acc;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_FETCH;
            retired <= retired + 1'b1;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_acc_core.sv
// Directed bench for mc_acc_core: a 16-bit core with a wait-state memory model
// and a 24-bit/16-register core with a zero-wait memory.
module tb_mc_acc_core;

  logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1;
  always #5 clk = ~clk;

  // 16-bit core
  logic        a_req, a_we, a_ack, a_halt, a_ill;
  logic [11:0] a_addr, a_pc;
  logic [15:0] a_wdata, a_rdata, a_ir, a_acc;
  logic [31:0] a_ret;

  // 24-bit core
  logic        b_req, b_we, b_ack, b_halt, b_ill;
  logic [19:0] b_addr, b_pc;
  logic [23:0] b_wdata, b_rdata, b_ir, b_acc;
  logic [15:0] b_ret;

  mc_acc_core #(.DATA_W(16), .REG_CNT(8), .RESET_PC(12'h000), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ack(a_ack), .pc(a_pc), .ir(a_ir),
    .acc(a_acc), .halted(a_halt), .illegal(a_ill), .retired(a_ret)
  );

  mc_acc_core #(.DATA_W(24), .REG_CNT(16), .RESET_PC(20'h00000), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ack(b_ack), .pc(b_pc), .ir(b_ir),
    .acc(b_acc), .halted(b_halt), .illegal(b_ill), .retired(b_ret)
  );

  logic [15:0] mem_a [0:4095];
  logic [23:0] mem_b [0:4095];

  int n_cmp = 0, n_bad = 0;
  int a_wcnt = 0, a_wtgt = 0, stab_bad = 0, wait_seen = 0, reqcyc = 0;
  bit rnd = 0, spur = 0, hold = 0, a_pend = 0;
  logic [11:0] hold_addr = 12'h010, s_addr;
  logic        s_we;
  logic [15:0] s_wdata;

  initial begin a_ack = 1'b0; a_rdata = '0; b_ack = 1'b0; b_rdata = '0; end

  // Memory A: commits on the ack edge, answers at negedge with 0..3 waits.
  always @(posedge clk) begin
    if (rst) a_wcnt = 0;
    else if (a_req && a_ack) begin
      if (a_we) mem_a[a_addr] = a_wdata;
      a_wcnt = 0;
      a_wtgt = rnd ? int'($urandom_range(0, 3)) : 0;
    end
  end

  always @(negedge clk) begin
    if (a_req) begin
      reqcyc++;
      if (a_pend && (a_addr !== s_addr || a_we !== s_we || (a_we && a_wdata !== s_wdata)))
        stab_bad++;
      s_addr = a_addr; s_we = a_we; s_wdata = a_wdata;
      if (!(hold && a_addr == hold_addr) && a_wcnt >= a_wtgt) begin
        a_ack = 1'b1; a_rdata = mem_a[a_addr]; a_pend = 0;
      end else begin
        a_ack = 1'b0; a_wcnt++; wait_seen++; a_pend = 1;
      end
    end else begin
      a_ack  = spur && ($urandom_range(0, 1) == 1);
      a_pend = 0;
    end
  end

  always @(posedge clk)
    if (!rst_b && b_req && b_ack && b_we) mem_b[b_addr[11:0]] = b_wdata;

  always @(negedge clk) begin
    b_ack   = b_req;
    b_rdata = mem_b[b_addr[11:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    for (int k = 0; k < 4096; k++) mem_a[k] = 16'h0000;
  endtask

  task automatic restart_a();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_halt_a(input string tag);
    int n = 0;
    while (!a_halt && n < 600) begin @(negedge clk); n++; end
    chk({tag, "_halt"}, 64'(a_halt), 64'h1);
  endtask

  task automatic wait_ret_a(input int r, input string tag);
    int n = 0;
    while (a_ret != 32'(r) && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_ret"}, 64'(a_ret), 64'(r));
  endtask

  task automatic load_prog1();
    clear_a();
    mem_a[12'h000] = 16'h0010;  // LDA 0x010
    mem_a[12'h001] = 16'h4011;  // ADD 0x011
    mem_a[12'h002] = 16'h1012;  // STA 0x012
    mem_a[12'h003] = 16'hE000;  // HALT
    mem_a[12'h010] = 16'h0005;
    mem_a[12'h011] = 16'hFFFE;
  endtask

  task automatic check_prog1(input string t);
    chk({t, "_m012"},    64'(mem_a[12'h012]), 64'h0003);
    chk({t, "_acc"},     64'(a_acc),          64'h0003);
    chk({t, "_retired"}, 64'(a_ret),          64'h3);
    chk({t, "_pc"},      64'(a_pc),           64'h004);
    chk({t, "_illegal"}, 64'(a_ill),          64'h0);
  endtask

  initial begin
    int n, r0;
    // reset state and first request
    load_prog1();
    repeat (3) @(negedge clk);
    chk("rst_req",     64'(a_req),  64'h0);
    chk("rst_pc",      64'(a_pc),   64'h000);
    chk("rst_ir",      64'(a_ir),   64'h0000);
    chk("rst_acc",     64'(a_acc),  64'h0000);
    chk("rst_retired", 64'(a_ret),  64'h0);
    chk("rst_halted",  64'(a_halt), 64'h0);
    chk("rst_illegal", 64'(a_ill),  64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req",  64'(a_req),  64'h1);
    chk("first_we",   64'(a_we),   64'h0);
    chk("first_addr", 64'(a_addr), 64'h000);

    // program 1, zero-wait memory
    wait_halt_a("p1");
    check_prog1("p1");

    // program 1 again with random waits and stray acks while idle
    rst = 1'b1; load_prog1(); rnd = 1; spur = 1; stab_bad = 0; wait_seen = 0;
    restart_a();
    wait_halt_a("p1w");
    check_prog1("p1w");
    chk("p1w_stable",    64'(stab_bad),       64'h0);
    chk("p1w_waited",    64'(wait_seen > 0),  64'h1);
    rnd = 0; spur = 0;

    // ADDI sign extension, JZ not taken then taken
    rst = 1'b1; clear_a();
    mem_a[12'h000] = 16'hCFFF;  // ADDI -1
    mem_a[12'h001] = 16'h3020;  // JZ 0x020
    mem_a[12'h002] = 16'h5030;  // SUB 0x030
    mem_a[12'h003] = 16'h3020;  // JZ 0x020
    mem_a[12'h020] = 16'hE000;
    mem_a[12'h030] = 16'hFFFF;
    restart_a();
    wait_ret_a(1, "jz1");
    chk("addi_acc",     64'(a_acc),  64'hFFFF);
    wait_ret_a(2, "jz2");
    chk("jz_nt_addr",   64'(a_addr), 64'h002);
    chk("jz_nt_req",    64'(a_req),  64'h1);
    wait_ret_a(3, "jz3");
    chk("sub_acc",      64'(a_acc),  64'h0000);
    wait_ret_a(4, "jz4");
    chk("jz_t_addr",    64'(a_addr), 64'h020);
    chk("jz_t_pc",      64'(a_pc),   64'h020);
    wait_halt_a("jz");
    chk("jz_end_pc",    64'(a_pc),   64'h021);
    chk("jz_end_ret",   64'(a_ret),  64'h4);

    // PC wrap from 0xFFF to 0
    rst = 1'b1; clear_a();
    mem_a[12'h000] = 16'h3FFF;  // JZ 0xFFF (taken first time, not after ADDI)
    mem_a[12'h001] = 16'hE000;
    mem_a[12'hFFF] = 16'hC001;  // ADDI 1
    restart_a();
    wait_ret_a(1, "wrap1");
    chk("wrap_fetch_fff", 64'(a_addr), 64'hFFF);
    wait_ret_a(2, "wrap2");
    chk("wrap_fetch_000", 64'(a_addr), 64'h000);
    wait_halt_a("wrap");
    chk("wrap_acc",     64'(a_acc),  64'h0001);
    chk("wrap_ret",     64'(a_ret),  64'h3);
    chk("wrap_pc",      64'(a_pc),   64'h002);

    // illegal opcode
    rst = 1'b1; clear_a();
    mem_a[12'h000] = 16'hD000;  // NOP
    mem_a[12'h001] = 16'hF123;
    restart_a();
    wait_halt_a("ill");
    chk("ill_flag",     64'(a_ill),  64'h1);
    chk("ill_ret",      64'(a_ret),  64'h1);
    chk("ill_pc",       64'(a_pc),   64'h002);
    r0 = reqcyc;
    repeat (8) @(negedge clk);
    chk("ill_no_req",   64'(reqcyc), 64'(r0));
    chk("ill_ret_hold", 64'(a_ret),  64'h1);
    chk("ill_sticky",   64'(a_halt & a_ill), 64'h1);

    // reset while MEM_RD waits for ack
    rst = 1'b1; clear_a();
    mem_a[12'h000] = 16'hC005;  // ADDI 5
    mem_a[12'h001] = 16'h9003;  // MVTO R3
    mem_a[12'h002] = 16'h0010;  // LDA 0x010, never acked
    mem_a[12'h010] = 16'h1234;
    hold = 1; hold_addr = 12'h010;
    restart_a();
    n = 0;
    while (!(a_req && a_addr == 12'h010) && n < 200) begin @(negedge clk); n++; end
    chk("mrd_req_seen", 64'(a_req),  64'h1);
    chk("mrd_acc",      64'(a_acc),  64'h0005);
    repeat (3) @(negedge clk);
    chk("mrd_stall",    64'(a_req),  64'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrd_rst_drop", 64'(a_req),  64'h0);
    hold = 0;
    mem_a[12'h000] = 16'hA003;  // MVFR R3
    mem_a[12'h001] = 16'hE000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrd_refetch_req",  64'(a_req),  64'h1);
    chk("mrd_refetch_addr", 64'(a_addr), 64'h000);
    wait_halt_a("mrd");
    chk("mrd_r3_cleared",   64'(a_acc),  64'h0000);
    chk("mrd_ret",          64'(a_ret),  64'h1);

    // 24-bit, 16-register core
    for (int k = 0; k < 4096; k++) mem_b[k] = 24'h000000;
    mem_b[0]  = 24'h000010;  // LDA 0x010
    mem_b[1]  = 24'h900005;  // MVTO R5
    mem_b[2]  = 24'h000011;  // LDA 0x011
    mem_b[3]  = 24'hB00005;  // ADDR R5
    mem_b[4]  = 24'h90001C;  // MVTO R12 (index uses low 4 bits)
    mem_b[5]  = 24'hCFFFFF;  // ADDI -1
    mem_b[6]  = 24'hA00005;  // MVFR R5
    mem_b[7]  = 24'hB0000C;  // ADDR R12
    mem_b[8]  = 24'h100012;  // STA 0x012
    mem_b[9]  = 24'hE00000;
    mem_b[16] = 24'h800001;
    mem_b[17] = 24'h9ABCDE;
    rst_b = 1'b0;
    n = 0;
    while (b_ret != 16'd4 && n < 200) begin @(negedge clk); n++; end
    chk("b_addr_wrap",  64'(b_acc),  64'h1ABCDF);
    n = 0;
    while (b_ret != 16'd6 && n < 200) begin @(negedge clk); n++; end
    chk("b_addi",       64'(b_acc),  64'h1ABCDE);
    n = 0;
    while (b_ret != 16'd7 && n < 200) begin @(negedge clk); n++; end
    chk("b_mvfr_r5",    64'(b_acc),  64'h800001);
    n = 0;
    while (!b_halt && n < 300) begin @(negedge clk); n++; end
    chk("b_halt",       64'(b_halt), 64'h1);
    chk("b_acc",        64'(b_acc),  64'h9ABCE0);
    chk("b_m012",       64'(mem_b[18]), 64'h9ABCE0);
    chk("b_ret",        64'(b_ret),  64'h9);
    chk("b_pc",         64'(b_pc),   64'h0000A);
    chk("b_illegal",    64'(b_ill),  64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
